// File: rtl/spi_pixel_rx_if.sv
// spi_pixel_rx_if: SPI pins plus line-buffer write port of the pixel receiver
// Ports:
//   spi_sclk, spi_mosi, spi_cs_n : SPI slave inputs (asynchronous to CLK)
//   Data[8:0]                    : {frame-start flag, pixel} presented to the line buffer
//   clk_SPI                      : level write strobe to the line buffer
//   Busy, Overrun, Pixel_Count   : status
// Modports: master = SPI master / buffer side, slave = receiver.
interface spi_pixel_rx_if;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic [8:0]  Data;
    logic        clk_SPI;
    logic        Busy;
    logic        Overrun;
    logic [15:0] Pixel_Count;
    modport master (output spi_sclk, spi_mosi, spi_cs_n,
                    input  Data, clk_SPI, Busy, Overrun, Pixel_Count);
    modport slave  (input  spi_sclk, spi_mosi, spi_cs_n,
                    output Data, clk_SPI, Busy, Overrun, Pixel_Count);
endinterface

// File: rtl/spi_pixel_rx.sv
// spi_pixel_rx: SPI-slave pixel deserialiser driving the line buffer with a 9-bit word and level strobe
// Ports:
//   CLK   : system clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : slave modport; SPI pins in, Data/clk_SPI/Busy/Overrun/Pixel_Count out
module spi_pixel_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter int         STROBE_HIGH = 2,
    parameter int         STROBE_LOW  = 2,
    parameter logic [7:0] CMD_FRAME   = 8'h01,
    parameter logic [7:0] CMD_LINE    = 8'h02
) (
    input logic           CLK,
    input logic           reset,
    spi_pixel_rx_if.slave bus
);
    localparam int CW = $clog2((STROBE_HIGH > STROBE_LOW ? STROBE_HIGH : STROBE_LOW) + 1);

    typedef enum logic [1:0] {IDLE, CMD, PIXEL, DROP} rx_state_t;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} st_state_t;

    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
    logic                   sclk_d, cs_d;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;
    logic                   frame_flag;
    rx_state_t              rx;
    st_state_t              st;
    logic [CW-1:0]          cnt;
    logic [8:0]             pend;
    logic                   pend_v;

    logic        sclk_s, mosi_s, cs_s;
    logic        sclk_rise, cs_fall, cs_rise, byte_done, push, last_low, consume;
    logic [7:0]  byte_val;
    logic [8:0]  word, setup_word;
    logic [15:0] pc_next;

    always_comb begin
        sclk_s     = sclk_q[SYNC_STAGES-1];
        mosi_s     = mosi_q[SYNC_STAGES-1];
        cs_s       = cs_q[SYNC_STAGES-1];
        sclk_rise  = sclk_s && !sclk_d && !cs_s;
        cs_fall    = cs_d && !cs_s;
        cs_rise    = cs_s && !cs_d;
        byte_val   = {shreg, mosi_s};
        byte_done  = sclk_rise && bit_cnt == 3'd7;
        push       = byte_done && rx == PIXEL;
        word       = {frame_flag, byte_val};
        last_low   = st == S_LOW && cnt == CW'(STROBE_LOW - 1);
        consume    = last_low && pend_v;
        // S_SETUP is entered either from idle with the fresh word or from S_LOW with pending
        setup_word = st == S_IDLE ? word : pend;
        pc_next    = setup_word[8] ? 16'd1 : (&bus.Pixel_Count ? bus.Pixel_Count : bus.Pixel_Count + 16'd1);
    end

    assign bus.Busy = st != S_IDLE || pend_v;

    always_ff @(posedge CLK) begin
        if (reset) begin
            sclk_q <= '0;
            mosi_q <= '0;
            cs_q   <= '1;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.spi_mosi};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], bus.spi_cs_n};
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rx         <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            frame_flag <= 1'b0;
        end else begin
            // deselect discards any partial byte
            if (cs_s)
                bit_cnt <= 3'd0;
            else if (sclk_rise) begin
                shreg   <= byte_val[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (cs_rise)
                rx <= IDLE;
            else
                case (rx)
                    IDLE: if (cs_fall) rx <= CMD;
                    CMD: if (byte_done) begin
                        rx <= (byte_val == CMD_FRAME || byte_val == CMD_LINE) ? PIXEL : DROP;
                        if (byte_val == CMD_FRAME) frame_flag <= 1'b1;
                    end
                    PIXEL: if (push) frame_flag <= 1'b0;
                    default: ;
                endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            st              <= S_IDLE;
            cnt             <= '0;
            pend            <= 9'd0;
            pend_v          <= 1'b0;
            bus.Data        <= 9'd0;
            bus.clk_SPI     <= 1'b0;
            bus.Overrun     <= 1'b0;
            bus.Pixel_Count <= 16'd0;
        end else begin
            case (st)
                S_IDLE: if (push) begin
                    st              <= S_SETUP;
                    bus.Data        <= setup_word;
                    bus.Pixel_Count <= pc_next;
                end
                S_SETUP: begin
                    st          <= S_HIGH;
                    bus.clk_SPI <= 1'b1;
                    cnt         <= '0;
                end
                S_HIGH: if (cnt == CW'(STROBE_HIGH - 1)) begin
                    st          <= S_LOW;
                    bus.clk_SPI <= 1'b0;
                    cnt         <= '0;
                end else
                    cnt <= cnt + CW'(1);
                S_LOW: if (last_low) begin
                    st <= pend_v ? S_SETUP : S_IDLE;
                    if (pend_v) begin
                        bus.Data        <= setup_word;
                        bus.Pixel_Count <= pc_next;
                    end
                end else
                    cnt <= cnt + CW'(1);
            endcase
            // a consume in the same cycle frees the slot before the push lands
            if (push && st != S_IDLE) begin
                if (!pend_v || consume) begin
                    pend   <= word;
                    pend_v <= 1'b1;
                end else
                    bus.Overrun <= 1'b1;
            end else if (consume)
                pend_v <= 1'b0;
        end
    end
endmodule
